dino_jump_ctrl: RTL and testbench

Sequencer between the debounced player buttons and the dino sprite. It divides the per-frame tick into the countdown enable for the `button_debounce` instances. It captures jump presses and arbitrates jump against duck. It runs the jump-arc state machine that produces the dino's height above ground for the renderer and collision logic.

---
 rtl/dino_jump_ctrl.sv | 155 +++++++++++++++
 tb/tb_dino_jump_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dino_jump_ctrl.sv
// Dino jump sequencer: frame-tick prescaler for the debouncers, jump capture/arbitration and jump-arc FSM.
// Optional feature macro DINO_AUTO_JUMP_EN: a held jump_btn level launches (and re-launches) jumps.
module dino_jump_ctrl #(
    parameter int unsigned TICK_DIV    = 4,
    parameter int unsigned RISE_STEP   = 4,
    parameter int unsigned FALL_STEP   = 4,
    parameter int unsigned JUMP_MAX    = 32,
    parameter int unsigned HANG_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       jump_btn,
    input  logic       duck_btn,
    input  logic       game_over,
    output logic       deb_tick,
    output logic [5:0] dino_y,
    output logic       ducking,
    output logic       airborne,
    output logic       jump_start,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_RUN  = 3'd0,
        S_DUCK = 3'd1,
        S_RISE = 3'd2,
        S_HANG = 3'd3,
        S_FALL = 3'd4
    } state_e;

    localparam logic [3:0] PRESC_LAST = 4'(TICK_DIV - 1);
    localparam logic [6:0] RISE7      = 7'(RISE_STEP);
    localparam logic [6:0] FALL7      = 7'(FALL_STEP);
    localparam logic [6:0] MAX7       = 7'(JUMP_MAX);
    localparam logic [3:0] HANG4      = 4'(HANG_FRAMES);

    state_e     state_q, state_d;
    logic [3:0] presc_q, presc_d;
    logic       pend_q, pend_d;
    logic [3:0] hang_q, hang_d;
    logic [5:0] y_q, y_d;
    logic       jump_prev_q, jump_prev_d;

    logic       grounded;
    logic       jump_edge;
    logic       jump_req;
    logic [6:0] rise_sum;
    logic [6:0] rise_clip;
    logic [6:0] fall_clip;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            presc_q     <= '0;
            pend_q      <= 1'b0;
            hang_q      <= '0;
            y_q         <= '0;
            jump_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            pend_q      <= pend_d;
            hang_q      <= hang_d;
            y_q         <= y_d;
            jump_prev_q <= jump_prev_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        pend_d      = pend_q;
        hang_d      = hang_q;
        y_d         = y_q;
        jump_prev_d = jump_btn;
        deb_tick    = 1'b0;
        jump_start  = 1'b0;

        grounded  = (state_q == S_RUN) || (state_q == S_DUCK);
        jump_edge = jump_btn & ~jump_prev_q;
`ifdef DINO_AUTO_JUMP_EN
        jump_req  = grounded & (pend_q | jump_edge | jump_btn);
`else
        jump_req  = grounded & (pend_q | jump_edge);
`endif

        // 7-bit intermediates so the step cannot wrap before saturation.
        rise_sum  = {1'b0, y_q} + RISE7;
        rise_clip = (rise_sum >= MAX7) ? MAX7 : rise_sum;
        fall_clip = ({1'b0, y_q} > FALL7) ? ({1'b0, y_q} - FALL7) : 7'd0;

        if (frame_tick) begin
            if (presc_q == PRESC_LAST) begin
                deb_tick = 1'b1;
                presc_d  = '0;
            end else begin
                presc_d = presc_q + 4'd1;
            end
        end

        // Edges seen while airborne are dropped; a pending jump lives until the next tick.
        if (game_over || frame_tick) begin
            pend_d = 1'b0;
        end else if (grounded && jump_edge) begin
            pend_d = 1'b1;
        end

        if (frame_tick && !game_over) begin
            case (state_q)
                S_RUN, S_DUCK: begin
                    if (jump_req) begin
                        state_d    = S_RISE;
                        jump_start = 1'b1;
                    end else if (duck_btn) begin
                        state_d = S_DUCK;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_RISE: begin
                    if (duck_btn) begin
                        state_d = S_FALL;
                    end else begin
                        y_d = rise_clip[5:0];
                        if (rise_clip == MAX7) begin
                            state_d = S_HANG;
                            hang_d  = HANG4;
                        end
                    end
                end
                S_HANG: begin
                    if (duck_btn || hang_q == 4'd1) begin
                        state_d = S_FALL;
                    end else begin
                        hang_d = hang_q - 4'd1;
                    end
                end
                S_FALL: begin
                    y_d = fall_clip[5:0];
                    if (fall_clip == 7'd0) begin
                        state_d = duck_btn ? S_DUCK : S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    assign dino_y    = y_q;
    assign ducking   = (state_q == S_DUCK);
    assign airborne  = (state_q == S_RISE) || (state_q == S_HANG) || (state_q == S_FALL);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Self-checking bench for dino_jump_ctrl: random and directed frames against a trajectory-level model.
module tb_dino_jump_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int RISE_STEP   = 4;
    localparam int FALL_STEP   = 4;
    localparam int JUMP_MAX    = 32;
    localparam int HANG_FRAMES = 3;
    // Ticks after launch spent going up (climb plus apex hold) before descent starts.
    localparam int RISE_TICKS  = (JUMP_MAX + RISE_STEP - 1) / RISE_STEP;
    localparam int UP_TICKS    = RISE_TICKS + HANG_FRAMES;

    // clock / reset
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       jump_btn = 1'b0;
    logic       duck_btn = 1'b0;
    logic       game_over = 1'b0;
    logic       deb_tick;
    logic [5:0] dino_y;
    logic       ducking;
    logic       airborne;
    logic       jump_start;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    dino_jump_ctrl #(
        .TICK_DIV(TICK_DIV), .RISE_STEP(RISE_STEP), .FALL_STEP(FALL_STEP),
        .JUMP_MAX(JUMP_MAX), .HANG_FRAMES(HANG_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .jump_btn(jump_btn),
        .duck_btn(duck_btn), .game_over(game_over), .deb_tick(deb_tick),
        .dino_y(dino_y), .ducking(ducking), .airborne(airborne),
        .jump_start(jump_start), .dbg_state(dbg_state)
    );

    // scoreboard: {deb_tick, jump_start, dino_y[5:0], ducking, airborne}
    logic [9:0] exp_q[$];
    logic [9:0] exp_now;
    logic [9:0] exp_e;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         mon_en = 0;

    // reference model state
    int m_cnt, m_y, m_k;
    bit m_prev, m_pend, m_air, m_desc, m_pose;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_y = 0; m_k = 0;
        m_prev = 0; m_pend = 0; m_air = 0; m_desc = 0; m_pose = 0;
    endtask

    task automatic model_step(input bit ft, input bit jb, input bit db, input bit go);
        bit edge_seen, req, e_deb, e_js;
        edge_seen = jb && !m_prev;
        req = !m_air && (m_pend || edge_seen);
`ifdef DINO_AUTO_JUMP_EN
        req = req || (!m_air && jb);
`endif
        e_deb = ft && (((m_cnt + 1) % TICK_DIV) == 0);
        e_js  = 0;
        if (ft) m_cnt++;
        if (go) begin
            m_pend = 0;
        end else if (ft) begin
            if (!m_air) begin
                if (req) begin
                    m_air = 1; m_k = 0; m_desc = 0; m_pose = 0; e_js = 1;
                end else begin
                    m_pose = db;
                end
            end else if (!m_desc) begin
                m_k++;
                if (db) begin
                    m_desc = 1;
                end else begin
                    m_y = (m_k * RISE_STEP < JUMP_MAX) ? m_k * RISE_STEP : JUMP_MAX;
                    if (m_k == UP_TICKS) m_desc = 1;
                end
            end else begin
                m_y = (m_y > FALL_STEP) ? m_y - FALL_STEP : 0;
                if (m_y == 0) begin
                    m_air = 0; m_pose = db;
                end
            end
            m_pend = 0;
        end else if (!m_air && edge_seen) begin
            m_pend = 1;
        end
        m_prev = jb;
        if (ft) exp_q.push_back({e_deb, e_js, 6'(m_y), m_pose, m_air});
    endtask

    // driver tasks
    task automatic cyc(input bit ft, input bit jb, input bit db, input bit go);
        @(posedge clk); #1;
        frame_tick = ft; jump_btn = jb; duck_btn = db; game_over = go;
        model_step(ft, jb, db, go);
    endtask

    task automatic frames(input int n, input bit jb, input bit db, input bit go);
        for (int i = 0; i < n; i++) begin
            cyc(0, jb, db, go);
            cyc(1, jb, db, go);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        mon_en = 0;
        rst_n = 0; frame_tick = 0; jump_btn = 0; duck_btn = 0; game_over = 0;
        @(posedge clk); #1;
        chk("reset_dino_y", dino_y, 0);
        chk("reset_airborne", airborne, 0);
        chk("reset_ducking", ducking, 0);
        chk("reset_deb_tick", deb_tick, 0);
        chk("reset_jump_start", jump_start, 0);
        rst_n = 1;
        model_reset();
        exp_q.delete();
        exp_now = '0;
        mon_en = 1;
    endtask

    // monitor: registered outputs every cycle, pulses popped on each frame tick
    always @(negedge clk) begin
        if (mon_en) begin
            chk("dino_y", dino_y, exp_now[7:2]);
            chk("ducking", ducking, exp_now[1]);
            chk("airborne", airborne, exp_now[0]);
            if (frame_tick) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("deb_tick", deb_tick, exp_e[9]);
                    chk("jump_start", jump_start, exp_e[8]);
                    exp_now = exp_e;
                end
            end else begin
                chk("deb_tick_idle", deb_tick, 0);
                chk("jump_start_idle", jump_start, 0);
            end
        end
    end

    initial begin
        bit jb, db, go;
        int go_left;
        do_reset();
        // prescaler only
        frames(8, 0, 0, 0);
        // full jump from an edge between ticks
        frames(1, 1, 0, 0);
        frames(21, 0, 0, 0);
        // jump and duck before the same tick, then fast-drop at y=16
        frames(1, 1, 1, 0);
        frames(4, 0, 0, 0);
        frames(6, 0, 1, 0);
        // launch from DUCK, freeze at y=20 with a jump edge inside the freeze
        frames(1, 1, 0, 0);
        frames(5, 0, 0, 0);
        frames(2, 0, 0, 1);
        frames(3, 1, 0, 1);
        frames(3, 1, 0, 0);
        frames(20, 0, 0, 0);
        // freeze on the ground with a jump edge during it
        frames(2, 0, 0, 1);
        frames(2, 1, 0, 1);
        frames(3, 1, 0, 0);
        frames(25, 0, 0, 0);
        // hold jump through landing
        frames(1, 0, 0, 0);
        frames(45, 1, 0, 0);
        frames(25, 0, 0, 0);
        // random traffic
        jb = 0; db = 0; go = 0; go_left = 0;
        for (int i = 0; i < 4000; i++) begin
            bit ft;
            ft = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) jb = !jb;
            if ($urandom_range(0, 11) == 0) db = !db;
            if (ft) begin
                if (go_left > 0) go_left--;
                else if ($urandom_range(0, 40) == 0) go_left = $urandom_range(1, 5);
                go = (go_left > 0);
            end
            cyc(ft, jb, db, go);
        end
        // reset in the middle of a jump
        frames(1, 0, 0, 0);
        frames(1, 1, 0, 0);
        frames(6, 0, 0, 0);
        do_reset();
        frames(8, 0, 0, 0);
        cyc(0, 0, 0, 0);
        @(negedge clk); #1;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
